// File: rtl/gpu_instruction_decoder_pkg.sv
// Shared widths, opcode and engine constants for the GPU instruction decoder.
// Opcode -> engine mapping lives here so the top and any user agree on it.
package gpu_instruction_decoder_pkg;

    localparam int WIDTH_BITS   = 10;
    localparam int HEIGHT_BITS  = 9;
    localparam int CHANNEL_BITS = 5;

    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_LINE  = 4'd1;
    localparam logic [3:0] OP_RECT  = 4'd2;
    localparam logic [3:0] OP_FILL  = 4'd3;
    localparam logic [3:0] OP_ARC   = 4'd4;
    localparam logic [3:0] OP_CLEAR = 4'd5;

    localparam logic [1:0] ENG_LINE = 2'd0;
    localparam logic [1:0] ENG_RECT = 2'd1;
    localparam logic [1:0] ENG_FILL = 2'd2;
    localparam logic [1:0] ENG_ARC  = 2'd3;

    function automatic logic is_draw(input logic [3:0] op);
        return (op >= OP_LINE) && (op <= OP_CLEAR);
    endfunction

    // CLEAR is executed by the fill engine.
    function automatic logic [1:0] engine_of(input logic [3:0] op);
        case (op)
            OP_RECT:           return ENG_RECT;
            OP_FILL, OP_CLEAR: return ENG_FILL;
            OP_ARC:            return ENG_ARC;
            default:           return ENG_LINE;
        endcase
    endfunction

endpackage

// File: rtl/gpu_decoder_watchdog.sv
// Cycle counter that flags when an engine has been waited on for CYCLES cycles.
// Saturates at the limit so a stalled enable never wraps back to a safe value.
module gpu_decoder_watchdog #(
    parameter int CYCLES = 1048576,
    parameter int BITS   = 21
) (
    input  logic clk,
    input  logic nrst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    logic [BITS-1:0] cnt;

    assign expire = (cnt == BITS'(CYCLES - 1));

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en && !expire)
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/gpu_instruction_decoder.sv
// Pops instructions from the GPU FIFO, latches their fields and hands them to
// one of four raster engines, waiting for done (or the watchdog) before the next.
module gpu_instruction_decoder
    import gpu_instruction_decoder_pkg::*;
#(
    parameter int SCREEN_W_MAX = 639,
    parameter int SCREEN_H_MAX = 479,
    parameter int WDOG_CYCLES  = 1048576,
    parameter int WDOG_BITS    = 21
) (
    input  logic                    clk,
    input  logic                    nrst,
    input  logic                    fifo_empty_i,
    output logic                    pop_instruction_o,
    input  logic [3:0]              opcode_i,
    input  logic [WIDTH_BITS-1:0]   x1_i,
    input  logic [WIDTH_BITS-1:0]   x2_i,
    input  logic [WIDTH_BITS-1:0]   rad_i,
    input  logic [HEIGHT_BITS-1:0]  y1_i,
    input  logic [HEIGHT_BITS-1:0]  y2_i,
    input  logic [CHANNEL_BITS-1:0] r_i,
    input  logic [CHANNEL_BITS-1:0] g_i,
    input  logic [CHANNEL_BITS-1:0] b_i,
    input  logic [2:0]              quad_i,
    output logic [3:0]              engine_start_o,
    input  logic [3:0]              engine_done_i,
    output logic [WIDTH_BITS-1:0]   x1_o,
    output logic [WIDTH_BITS-1:0]   x2_o,
    output logic [WIDTH_BITS-1:0]   rad_o,
    output logic [HEIGHT_BITS-1:0]  y1_o,
    output logic [HEIGHT_BITS-1:0]  y2_o,
    output logic [CHANNEL_BITS-1:0] r_o,
    output logic [CHANNEL_BITS-1:0] g_o,
    output logic [CHANNEL_BITS-1:0] b_o,
    output logic [2:0]              quad_o,
    output logic                    busy_o,
    output logic                    error_o,
    output logic [15:0]             instr_count_o
);

    typedef enum logic [1:0] {S_IDLE, S_DECODE, S_WAIT} state_t;

    state_t     state;
    logic [3:0] op;
    logic [1:0] sel;
    logic       wdog_expire;
    logic       sel_done;

    // Gated by nrst so a non-empty FIFO cannot see a pop while reset is held.
    assign pop_instruction_o = nrst && (state == S_IDLE) && !fifo_empty_i;
    assign busy_o            = (state != S_IDLE);
    assign sel_done          = engine_done_i[sel];

    gpu_decoder_watchdog #(
        .CYCLES (WDOG_CYCLES),
        .BITS   (WDOG_BITS)
    ) u_wdog (
        .clk    (clk),
        .nrst   (nrst),
        .clr    (state == S_DECODE),
        .en     (state == S_WAIT),
        .expire (wdog_expire)
    );

    // The CLEAR rewrite and the start pulse are staged at pop time so both are
    // already visible on the outputs during the DECODE cycle.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state          <= S_IDLE;
            op             <= OP_NOP;
            sel            <= ENG_LINE;
            engine_start_o <= '0;
            x1_o           <= '0;
            x2_o           <= '0;
            rad_o          <= '0;
            y1_o           <= '0;
            y2_o           <= '0;
            r_o            <= '0;
            g_o            <= '0;
            b_o            <= '0;
            quad_o         <= '0;
            error_o        <= 1'b0;
            instr_count_o  <= '0;
        end else begin
            engine_start_o <= '0;
            case (state)
                S_IDLE: begin
                    if (!fifo_empty_i) begin
                        op     <= opcode_i;
                        sel    <= engine_of(opcode_i);
                        rad_o  <= rad_i;
                        r_o    <= r_i;
                        g_o    <= g_i;
                        b_o    <= b_i;
                        quad_o <= quad_i;
                        if (opcode_i == OP_CLEAR) begin
                            x1_o <= '0;
                            y1_o <= '0;
                            x2_o <= WIDTH_BITS'(SCREEN_W_MAX);
                            y2_o <= HEIGHT_BITS'(SCREEN_H_MAX);
                        end else begin
                            x1_o <= x1_i;
                            y1_o <= y1_i;
                            x2_o <= x2_i;
                            y2_o <= y2_i;
                        end
                        if (is_draw(opcode_i))
                            engine_start_o <= 4'b0001 << engine_of(opcode_i);
                        state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (is_draw(op)) begin
                        state <= S_WAIT;
                    end else begin
                        if (op != OP_NOP)
                            error_o <= 1'b1;
                        instr_count_o <= instr_count_o + 1'b1;
                        state         <= S_IDLE;
                    end
                end
                S_WAIT: begin
                    // Done on the limit cycle wins over the watchdog.
                    if (sel_done || wdog_expire) begin
                        if (!sel_done)
                            error_o <= 1'b1;
                        instr_count_o <= instr_count_o + 1'b1;
                        state         <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gpu_instruction_decoder.sv
// Scoreboard bench: a FIFO model feeds the decoder, a reference model predicts
// start pulses and retirements, and an engine model answers with delayed done.
module tb_gpu_instruction_decoder;
    import gpu_instruction_decoder_pkg::*;

    localparam int WDOG = 16;

    typedef struct packed {
        logic [3:0]              op;
        logic [WIDTH_BITS-1:0]   x1;
        logic [WIDTH_BITS-1:0]   x2;
        logic [WIDTH_BITS-1:0]   rad;
        logic [HEIGHT_BITS-1:0]  y1;
        logic [HEIGHT_BITS-1:0]  y2;
        logic [CHANNEL_BITS-1:0] r;
        logic [CHANNEL_BITS-1:0] g;
        logic [CHANNEL_BITS-1:0] b;
        logic [2:0]              quad;
    } instr_t;

    typedef struct packed {
        logic [3:0]              start;
        logic [WIDTH_BITS-1:0]   x1;
        logic [WIDTH_BITS-1:0]   x2;
        logic [WIDTH_BITS-1:0]   rad;
        logic [HEIGHT_BITS-1:0]  y1;
        logic [HEIGHT_BITS-1:0]  y2;
        logic [CHANNEL_BITS-1:0] r;
        logic [CHANNEL_BITS-1:0] g;
        logic [CHANNEL_BITS-1:0] b;
        logic [2:0]              quad;
    } out_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic nrst;
    logic fifo_empty_i;
    logic pop_instruction_o;
    instr_t head;
    logic [3:0] engine_start_o;
    logic [3:0] engine_done_i;
    logic [WIDTH_BITS-1:0] x1_o, x2_o, rad_o;
    logic [HEIGHT_BITS-1:0] y1_o, y2_o;
    logic [CHANNEL_BITS-1:0] r_o, g_o, b_o;
    logic [2:0] quad_o;
    logic busy_o, error_o;
    logic [15:0] instr_count_o;

    gpu_instruction_decoder #(
        .SCREEN_W_MAX (639),
        .SCREEN_H_MAX (479),
        .WDOG_CYCLES  (WDOG),
        .WDOG_BITS    (5)
    ) dut (
        .clk               (clk),
        .nrst              (nrst),
        .fifo_empty_i      (fifo_empty_i),
        .pop_instruction_o (pop_instruction_o),
        .opcode_i          (head.op),
        .x1_i              (head.x1),
        .x2_i              (head.x2),
        .rad_i             (head.rad),
        .y1_i              (head.y1),
        .y2_i              (head.y2),
        .r_i               (head.r),
        .g_i               (head.g),
        .b_i               (head.b),
        .quad_i            (head.quad),
        .engine_start_o    (engine_start_o),
        .engine_done_i     (engine_done_i),
        .x1_o              (x1_o),
        .x2_o              (x2_o),
        .rad_o             (rad_o),
        .y1_o              (y1_o),
        .y2_o              (y2_o),
        .r_o               (r_o),
        .g_o               (g_o),
        .b_o               (b_o),
        .quad_o            (quad_o),
        .busy_o            (busy_o),
        .error_o           (error_o),
        .instr_count_o     (instr_count_o)
    );

    out_t cur;
    assign cur = {engine_start_o, x1_o, x2_o, rad_o, y1_o, y2_o, r_o, g_o, b_o, quad_o};
    logic [$bits(out_t)+18:0] all_out;
    assign all_out = {pop_instruction_o, busy_o, error_o, instr_count_o, cur};

    int checks = 0;
    int errors = 0;
    int gap_pct = 0;

    instr_t      fifo_q[$];
    out_t        exp_start[$];
    logic [16:0] exp_ret[$];
    int          resp_k[$];
    bit          resp_noise[$];
    int          m_count = 0;
    bit          m_err = 0;

    // Reference model: what the decoder must do with this instruction given
    // the engine will answer k cycles into WAIT.
    task automatic enqueue(input instr_t in, input int k, input bit noise);
        out_t e;
        fifo_q.push_back(in);
        if (in.op >= 4'd1 && in.op <= 4'd5) begin
            case (in.op)
                4'd1:    e.start = 4'b0001;
                4'd2:    e.start = 4'b0010;
                4'd4:    e.start = 4'b1000;
                default: e.start = 4'b0100;
            endcase
            e.x1 = (in.op == 4'd5) ? '0 : in.x1;
            e.y1 = (in.op == 4'd5) ? '0 : in.y1;
            e.x2 = (in.op == 4'd5) ? WIDTH_BITS'(639) : in.x2;
            e.y2 = (in.op == 4'd5) ? HEIGHT_BITS'(479) : in.y2;
            e.rad = in.rad; e.r = in.r; e.g = in.g; e.b = in.b; e.quad = in.quad;
            exp_start.push_back(e);
            resp_k.push_back(k);
            resp_noise.push_back(noise);
            if (k > WDOG) m_err = 1'b1;
        end else if (in.op != 4'd0) begin
            m_err = 1'b1;
        end
        m_count = (m_count + 1) % 65536;
        exp_ret.push_back({16'(m_count), m_err});
    endtask

    function automatic instr_t mk(input int op, input int x1, input int y1, input int x2,
                                  input int y2, input int rad, input int r, input int g,
                                  input int b, input int quad);
        instr_t t;
        t.op = 4'(op); t.x1 = WIDTH_BITS'(x1); t.y1 = HEIGHT_BITS'(y1);
        t.x2 = WIDTH_BITS'(x2); t.y2 = HEIGHT_BITS'(y2); t.rad = WIDTH_BITS'(rad);
        t.r = CHANNEL_BITS'(r); t.g = CHANNEL_BITS'(g); t.b = CHANNEL_BITS'(b);
        t.quad = 3'(quad);
        return t;
    endfunction

    // FIFO model: presents the head between edges, retires it on a seen pop.
    initial begin
        bit pop_seen;
        fifo_empty_i = 1'b1;
        head = '0;
        forever begin
            @(negedge clk);
            if (fifo_q.size() != 0 && $urandom_range(99) >= gap_pct) begin
                fifo_empty_i = 1'b0;
                head = fifo_q[0];
            end else begin
                fifo_empty_i = 1'b1;
                head = instr_t'({$urandom, $urandom, $urandom});
            end
            #1;
            pop_seen = pop_instruction_o;
            if (pop_seen) begin
                checks++;
                if (fifo_empty_i || busy_o) begin
                    errors++;
                    $display("FAIL pop_legal empty=%0b busy=%0b required empty=0 busy=0", fifo_empty_i, busy_o);
                end
            end
            @(posedge clk);
            if (pop_seen && !fifo_empty_i && nrst) void'(fifo_q.pop_front());
        end
    end

    // Engine model: done for the started engine k negedges later, optional
    // one-cycle pulse on every other engine's done right after start.
    int r_k, r_c;
    bit r_noise, r_active;
    logic [3:0] r_oh;
    always @(negedge clk) begin
        engine_done_i = 4'b0000;
        if (!nrst) begin
            r_active = 1'b0;
        end else begin
            if (r_active) begin
                r_c++;
                if (r_c == r_k) begin
                    engine_done_i = r_oh;
                    r_active = 1'b0;
                end else if (r_c == 1 && r_noise) begin
                    engine_done_i = ~r_oh;
                end
            end
            if (engine_start_o != 4'b0000 && resp_k.size() != 0) begin
                r_k = resp_k.pop_front();
                r_noise = resp_noise.pop_front();
                r_oh = engine_start_o;
                r_c = 0;
                r_active = 1'b1;
            end
        end
    end

    // Monitor: start pulses, retirements and parameter hold during WAIT.
    logic [15:0] last_count;
    bit in_wait;
    out_t held;
    always @(negedge clk) begin
        out_t e;
        logic [16:0] rr;
        if (!nrst) begin
            last_count = '0;
            in_wait = 1'b0;
        end else begin
            if (instr_count_o != last_count) begin
                last_count = instr_count_o;
                in_wait = 1'b0;
                checks++;
                if (exp_ret.size() == 0) begin
                    errors++;
                    $display("FAIL retire_unexpected count=%0d", instr_count_o);
                end else begin
                    rr = exp_ret.pop_front();
                    if ({instr_count_o, error_o, busy_o} !== {rr, 1'b0}) begin
                        errors++;
                        $display("FAIL retire count=%0d err=%0b busy=%0b required count=%0d err=%0b busy=0",
                                 instr_count_o, error_o, busy_o, rr[16:1], rr[0]);
                    end
                end
            end else if (in_wait && engine_start_o == 4'b0000) begin
                checks++;
                if (cur !== held) begin
                    errors++;
                    $display("FAIL hold got=%h required=%h", cur, held);
                end
            end
            if (engine_start_o != 4'b0000) begin
                checks++;
                if (exp_start.size() == 0) begin
                    errors++;
                    $display("FAIL start_unexpected got=%h", cur);
                end else begin
                    e = exp_start.pop_front();
                    if (cur !== e) begin
                        errors++;
                        $display("FAIL start got=%h required=%h", cur, e);
                    end
                end
                in_wait = 1'b1;
                held = cur;
                held.start = 4'b0000;
            end
        end
    end

    task automatic check_all_zero(input string name);
        checks++;
        if (all_out !== '0) begin
            errors++;
            $display("FAIL %s outputs=%h required=0", name, all_out);
        end
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while ((fifo_q.size() != 0 || exp_start.size() != 0 || exp_ret.size() != 0 || busy_o)
               && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) begin
            checks++;
            errors++;
            $display("FAIL %s timeout pending_ret=%0d required=0", name, exp_ret.size());
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset(input string name);
        @(posedge clk);
        #3 nrst = 1'b0;
        #1 check_all_zero(name);
        fifo_q.delete(); exp_start.delete(); exp_ret.delete();
        resp_k.delete(); resp_noise.delete();
        m_count = 0; m_err = 1'b0;
        repeat (2) @(posedge clk);
        #2 nrst = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        instr_t in;
        int n;
        int r;
        nrst = 1'b1;
        #1 nrst = 1'b0;
        @(negedge clk);
        check_all_zero("reset_state");
        @(posedge clk);
        #2 nrst = 1'b1;
        repeat (20) begin
            @(negedge clk);
            check_all_zero("idle_empty");
        end

        enqueue(mk(1, 10, 20, 100, 200, 0, 'h1F, 0, 0, 0), 5, 0);
        wait_idle("line", 200);
        enqueue(mk(5, 5, 7, 300, 100, 12, 3, 9, 27, 2), 3, 0);
        wait_idle("clear", 200);
        // Done on the watchdog's last cycle must not raise error.
        enqueue(mk(2, 1, 2, 3, 4, 0, 1, 1, 1, 0), WDOG, 1);
        wait_idle("wdog_coincident", 200);
        enqueue(mk(9, 1, 1, 1, 1, 1, 1, 1, 1, 1), 0, 0);
        enqueue(mk(0, 2, 2, 2, 2, 2, 2, 2, 2, 2), 0, 0);
        enqueue(mk(4, 50, 60, 0, 0, 33, 4, 5, 6, 3), 2, 0);
        wait_idle("illegal_nop_arc", 200);

        // Reset in the middle of WAIT abandons the instruction.
        enqueue(mk(2, 11, 12, 13, 14, 0, 7, 7, 7, 0), WDOG + 1, 0);
        n = 0;
        while (exp_start.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        checks++;
        if (busy_o !== 1'b1) begin
            errors++;
            $display("FAIL busy_in_wait got=%0b required=1", busy_o);
        end
        do_reset("async_reset_wait");
        enqueue(mk(1, 3, 4, 5, 6, 0, 8, 9, 10, 0), 1, 0);
        wait_idle("after_reset", 200);

        // Done one cycle past the limit: watchdog aborts, error raised.
        enqueue(mk(2, 21, 22, 23, 24, 0, 2, 3, 4, 1), WDOG + 1, 1);
        wait_idle("wdog_abort", 200);

        do_reset("reset_before_random");
        gap_pct = 30;
        repeat (60) begin
            in = instr_t'({$urandom, $urandom, $urandom});
            r = $urandom_range(0, 7);
            in.op = (r < 7) ? 4'($urandom_range(0, 5)) : 4'($urandom_range(6, 15));
            enqueue(in, ($urandom_range(0, 7) == 0) ? WDOG + int'($urandom_range(0, 1))
                                                    : int'($urandom_range(1, 6)),
                    bit'($urandom_range(0, 1)));
        end
        wait_idle("random", 5000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gpu_instruction_decoder.md
Name: gpu_instruction_decoder

Overview:
- Sits directly downstream of the GPU instruction FIFO.
- Pops one instruction at a time, latches its fields and decodes the opcode into a one-hot start pulse for one of four raster engines (line, rect outline, rect fill, arc).
- Holds the latched parameters stable until that engine signals done, then fetches the next instruction.
- Handles NOP, CLEAR (rewritten into a full-screen fill), illegal opcodes and hung engines via a watchdog.

Parameters:
- SCREEN_W_MAX, 639, x2 substituted for CLEAR (fits `WIDTH_BITS).
- SCREEN_H_MAX, 479, y2 substituted for CLEAR (fits `HEIGHT_BITS).
- WDOG_CYCLES, 1048576, max cycles in WAIT before abort.
- WDOG_BITS, 21, watchdog counter width; must hold WDOG_CYCLES.

Ports:
- clk  in  1  system clock.
- nrst  in  1  asynchronous active-low reset.
- fifo_empty_i  in  1  FIFO has no valid head.
- pop_instruction_o  out  1  pop FIFO head this cycle.
- opcode_i  in  4  head opcode.
- x1_i, x2_i, rad_i  in  `WIDTH_BITS each  head coordinates/radius.
- y1_i, y2_i  in  `HEIGHT_BITS each  head coordinates.
- r_i, g_i, b_i  in  `CHANNEL_BITS each  head colour.
- quad_i  in  3  head arc quadrant.
- engine_start_o  out  4  one-hot start pulse: [0] line, [1] rect outline, [2] fill, [3] arc.
- engine_done_i  in  4  per-engine one-cycle done pulse.
- x1_o, x2_o, rad_o, y1_o, y2_o, r_o, g_o, b_o, quad_o  out  same widths as inputs  latched parameters to engines.
- busy_o  out  1  decoder is not IDLE.
- error_o  out  1  sticky: illegal opcode or watchdog abort.
- instr_count_o  out  16  instructions retired (wraps).

Behaviour:
- Reset (async, nrst low): state IDLE; all outputs 0; latched fields 0; watchdog 0; error_o 0; instr_count_o 0. Mid-operation reset abandons the instruction; no start or pop may glitch during reset.
- FIFO head is combinational and valid only while fifo_empty_i=0. Fields are captured in the same cycle pop_instruction_o is asserted.
- IDLE:
  - If fifo_empty_i=0: assert pop_instruction_o for exactly 1 cycle, capture all fields, go to DECODE.
  - Otherwise stay in IDLE.
- DECODE (1 cycle), by opcode:
  - 0 NOP: instr_count+1, go to IDLE.
  - 1 LINE: start[0].
  - 2 RECT: start[1].
  - 3 FILL: start[2].
  - 4 ARC: start[3].
  - 5 CLEAR: overwrite x1=0, y1=0, x2=SCREEN_W_MAX, y2=SCREEN_H_MAX (colour kept), then start[2].
  - 6-15: set error_o, instr_count+1, go to IDLE. No start.
  - For opcodes 1-5: engine_start_o is high for exactly this one cycle; record the selected engine index; clear the watchdog; go to WAIT.
- WAIT:
  - Parameter outputs are held constant.
  - engine_done_i bit of the selected engine = 1: instr_count+1, go to IDLE. Done bits of other engines are ignored.
  - Watchdog increments each cycle; on reaching WDOG_CYCLES-1 without done: set error_o, instr_count+1, go to IDLE.
  - A done arriving in the same cycle as the watchdog limit counts as done; no error is set.
- Throughput: 3 cycles minimum per drawing instruction (IDLE, DECODE, WAIT with done in its first cycle); 2 cycles per NOP or illegal opcode.
- Pop is never asserted outside IDLE and never while fifo_empty_i=1, so at most one instruction is in flight.
- busy_o = (state != IDLE).
- error_o clears only on reset.
- instr_count_o wraps from 0xFFFF to 0.

Decomposition:
- Opcode constants (OP_NOP..OP_CLEAR) and engine index constants go in gpu_definitions.vh alongside the existing width macros. The state enum is local.
- One natural sub-module: gpu_decoder_watchdog (counter with clear/enable inputs and an expire output).

Test Plan:
- Reset then fifo_empty_i=1 for 20 cycles -> no pop, no start, busy_o=0, all outputs 0.
- Head LINE x1=10 y1=20 x2=100 y2=200 r=0x1F; done[0] 5 cycles after start -> pop 1 cycle, start=0001 one cycle later, x1_o..r_o held through WAIT, instr_count_o=1.
- CLEAR with x1=5 -> start=0100, x1_o=0, y1_o=0, x2_o=639, y2_o=479, colour passed through.
- Opcode 9, then NOP, then ARC quad=3 queued back-to-back -> error_o=1, no start for the first two, start=1000 with quad_o=3, count=3 after done[3].
- RECT started, done[3] pulsed and done[1] withheld, WDOG_CYCLES=16 -> remains in WAIT for 16 cycles, then error_o=1 and returns to IDLE; done[1] coincident with the limit in a rerun -> error_o stays 0.
- nrst asserted during WAIT -> all outputs 0 asynchronously; after release, the next head is fetched normally.
